ahb_dmem_slave: RTL and testbench

//  Synthesizable AHB-Lite data-memory slave, directly downstream of the pipeline_cpu_top D-bus master.

---
 rtl/ahb_dmem_slave_if.sv | 24 ++
 rtl/ahb_dmem_slave.sv | 100 ++++++++++
 tb/tb_ahb_dmem_slave.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dmem_slave_if.sv
// ahb_dmem_slave_if: AHB-Lite D-bus signal bundle between the CPU data master and the data-memory slave.
interface ahb_dmem_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_dmem_slave.sv
// ahb_dmem_slave: AHB-Lite word SRAM slave with byte lanes, programmable wait states,
// two-cycle ERROR responses and write-to-read bypass for pipelined transfers.
module ahb_dmem_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          READ_WAIT   = 1,
    parameter int          WRITE_WAIT  = 0
) (
    input logic             clk,
    input logic             rst_n,
    ahb_dmem_slave_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, WWAIT, WDATA, RWAIT, RDATA, ERR1, ERR2} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d, rdata_q, rdata_d, merged, fword;
    logic [1:0]        size_q, size_d, resp_q, resp_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d, accept, illegal, commit;
    logic [3:0]        lanes;
    logic [AW-1:0]     widx, fidx;
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] vld_q;
    logic              unused_ok;

    assign accept  = bus.HSEL && bus.HTRANS[1] && (state_q == IDLE || (ready_q && resp_q == 2'b00));
    assign illegal = bus.HSIZE > 3'd2 || (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
                     (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00) ||
                     bus.HADDR[31:AW+2] != BASE_ADDR[31:AW+2];
    assign commit  = state_q == WDATA;
    assign widx    = addr_q[AW+1:2];
    assign fidx    = accept ? bus.HADDR[AW+1:2] : addr_q[AW+1:2];
    assign lanes   = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                     size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, addr_q[31:AW+2]};

    // Words never written since reset read as zero via vld_q, so the array itself needs no reset.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = lanes[i] ? bus.HWDATA[8*i +: 8] : (vld_q[widx] ? mem_q[widx][8*i +: 8] : 8'h00);
        fword = (commit && fidx == widx) ? merged : (vld_q[fidx] ? mem_q[fidx] : 32'h0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            resp_q  <= 2'b00;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            if (commit) vld_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem_q[widx] <= merged;
    end

    always_comb begin
        addr_d  = accept ? bus.HADDR : addr_q;
        size_d  = accept ? bus.HSIZE[1:0] : size_q;
        cnt_d   = accept ? (bus.HWRITE ? 3'(WRITE_WAIT) : 3'(READ_WAIT)) - 3'd1
                         : cnt_q - {2'b00, cnt_q != 3'd0};
        state_d = state_q;
        case (state_q)
            IDLE, WDATA, RDATA:
                state_d = !accept ? IDLE : illegal ? ERR1 :
                          bus.HWRITE ? (WRITE_WAIT > 0 ? WWAIT : WDATA) :
                                       (READ_WAIT > 0 ? RWAIT : RDATA);
            WWAIT:   state_d = cnt_q == 3'd0 ? WDATA : WWAIT;
            RWAIT:   state_d = cnt_q == 3'd0 ? RDATA : RWAIT;
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d = state_d == WDATA || state_d == RDATA || state_d == ERR2;
        resp_d  = (state_d == ERR1 || state_d == ERR2) ? 2'b01 : 2'b00;
        rdata_d = state_d == RDATA ? fword : 32'h0;
    end

    assign bus.HRDATA    = rdata_q;
    assign bus.HREADYOUT = ready_q;
    assign bus.HRESP     = resp_q;
endmodule

// File: tb/tb_ahb_dmem_slave.sv
// tb_ahb_dmem_slave: directed vectors for the D-bus memory slave (default waits) plus
// hand sequences for error phases, back-to-back writes, bypass (READ_WAIT=0) and reset abort.
module tb_ahb_dmem_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_dmem_slave_if b0();
    ahb_dmem_slave_if b1();

    ahb_dmem_slave dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    ahb_dmem_slave #(.READ_WAIT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t v[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input vec_t x, output logic [31:0] rd, output logic [1:0] resp, output int lat);
        b0.HTRANS = 2'b10;
        b0.HWRITE = x.w;
        b0.HSIZE  = x.sz;
        b0.HADDR  = x.a;
        @(posedge clk); #1;
        b0.HTRANS = 2'b00;
        b0.HWDATA = x.wd;
        lat = -1;
        rd = '0;
        resp = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (b0.HREADYOUT) begin
                lat = k;
                rd = b0.HRDATA;
                resp = b0.HRESP;
                break;
            end
        end
        if (resp != 2'b00) @(negedge clk);
    endtask

    task automatic rd0(input string nm, input logic [31:0] a, input logic [31:0] exp);
        vec_t x;
        logic [31:0] rd;
        logic [1:0] resp;
        int lat;
        x = '{1'b0, 3'd2, a, 32'h0, 2'b00, exp, 2};
        xfer(x, rd, resp, lat);
        chk({nm, " data"}, rd, exp);
        chk({nm, " lat"}, 32'(lat), 32'd2);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        int          pulses;
        vec_t        x;
        v[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 2'b00, 32'h0,        1};
        v[1]  = '{1'b0, 3'd2, 32'h10,   32'h0,        2'b00, 32'hDEADBEEF, 2};
        v[2]  = '{1'b1, 3'd2, 32'h10,   32'h11223344, 2'b00, 32'h0,        1};
        v[3]  = '{1'b1, 3'd0, 32'h13,   32'hAA000000, 2'b00, 32'h0,        1};
        v[4]  = '{1'b0, 3'd2, 32'h10,   32'h0,        2'b00, 32'hAA223344, 2};
        v[5]  = '{1'b1, 3'd1, 32'h11,   32'hFFFFFFFF, 2'b01, 32'h0,        2};
        v[6]  = '{1'b1, 3'd3, 32'h10,   32'hFFFFFFFF, 2'b01, 32'h0,        2};
        v[7]  = '{1'b0, 3'd2, 32'h10,   32'h0,        2'b00, 32'hAA223344, 2};
        v[8]  = '{1'b0, 3'd2, 32'h1000, 32'h0,        2'b01, 32'h0,        2};
        v[9]  = '{1'b1, 3'd1, 32'h16,   32'hBEEF0000, 2'b00, 32'h0,        1};
        v[10] = '{1'b1, 3'd0, 32'h14,   32'h00000055, 2'b00, 32'h0,        1};
        v[11] = '{1'b0, 3'd2, 32'h14,   32'h0,        2'b00, 32'hBEEF0055, 2};
        v[12] = '{1'b0, 3'd2, 32'hFFC,  32'h0,        2'b00, 32'h0,        2};
        v[13] = '{1'b1, 3'd2, 32'hFFC,  32'h12345678, 2'b00, 32'h0,        1};
        v[14] = '{1'b0, 3'd2, 32'hFFC,  32'h0,        2'b00, 32'h12345678, 2};
        v[15] = '{1'b0, 3'd2, 32'h12,   32'h0,        2'b01, 32'h0,        2};
        v[16] = '{1'b0, 3'd0, 32'h17,   32'h0,        2'b00, 32'hBEEF0055, 2};

        {b0.HSEL, b0.HADDR, b0.HTRANS, b0.HWRITE, b0.HSIZE, b0.HBURST, b0.HMASTLOCK, b0.HWDATA} = '0;
        {b1.HSEL, b1.HADDR, b1.HTRANS, b1.HWRITE, b1.HSIZE, b1.HBURST, b1.HMASTLOCK, b1.HWDATA} = '0;
        b0.HSEL = 1'b1;
        b1.HSEL = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset ready", 32'(b0.HREADYOUT), 32'd0);
        chk("reset resp", 32'(b0.HRESP), 32'd0);
        chk("reset rdata", b0.HRDATA, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset ready", 32'(b0.HREADYOUT), 32'd0);
        chk("post-reset ready1", 32'(b1.HREADYOUT), 32'd0);

        for (int i = 0; i < 17; i++) begin
            xfer(v[i], rd, resp, lat);
            chk($sformatf("vec%0d resp", i), 32'(resp), 32'(v[i].resp));
            chk($sformatf("vec%0d data", i), rd, v[i].rd);
            chk($sformatf("vec%0d lat", i), 32'(lat), 32'(v[i].lat));
        end

        // Error response phases: ERROR with ready low, then ERROR with ready high, then idle
        @(negedge clk);
        b0.HTRANS = 2'b10; b0.HWRITE = 1'b0; b0.HSIZE = 3'd2; b0.HADDR = 32'h12;
        @(posedge clk); #1;
        b0.HTRANS = 2'b00;
        @(negedge clk);
        chk("err1 ready", 32'(b0.HREADYOUT), 32'd0);
        chk("err1 resp", 32'(b0.HRESP), 32'd1);
        @(negedge clk);
        chk("err2 ready", 32'(b0.HREADYOUT), 32'd1);
        chk("err2 resp", 32'(b0.HRESP), 32'd1);
        chk("err2 rdata", b0.HRDATA, 32'h0);
        @(negedge clk);
        chk("err done ready", 32'(b0.HREADYOUT), 32'd0);
        chk("err done resp", 32'(b0.HRESP), 32'd0);

        // Back-to-back writes with no idle gap
        b0.HTRANS = 2'b10; b0.HWRITE = 1'b1; b0.HSIZE = 3'd2; b0.HADDR = 32'h20;
        @(posedge clk); #1;
        b0.HWDATA = 32'hA5A5A5A5; b0.HADDR = 32'h24;
        @(negedge clk);
        chk("b2b pulse1", 32'(b0.HREADYOUT), 32'd1);
        @(posedge clk); #1;
        b0.HWDATA = 32'h5A5A5A5A; b0.HTRANS = 2'b00;
        @(negedge clk);
        chk("b2b pulse2", 32'(b0.HREADYOUT), 32'd1);
        @(negedge clk);
        chk("b2b done", 32'(b0.HREADYOUT), 32'd0);
        rd0("b2b rd20", 32'h20, 32'hA5A5A5A5);
        rd0("b2b rd24", 32'h24, 32'h5A5A5A5A);

        // Bypass on the zero-read-wait slave: read fetch coincides with the write commit
        @(negedge clk);
        b1.HTRANS = 2'b10; b1.HWRITE = 1'b1; b1.HSIZE = 3'd2; b1.HADDR = 32'h20;
        @(posedge clk); #1;
        b1.HWDATA = 32'h0BADF00D; b1.HWRITE = 1'b0;
        @(negedge clk);
        chk("byp wr pulse", 32'(b1.HREADYOUT), 32'd1);
        chk("byp wr rdata", b1.HRDATA, 32'h0);
        @(posedge clk); #1;
        b1.HTRANS = 2'b00;
        @(negedge clk);
        chk("byp rd pulse", 32'(b1.HREADYOUT), 32'd1);
        chk("byp rd data", b1.HRDATA, 32'h0BADF00D);
        b1.HTRANS = 2'b10; b1.HWRITE = 1'b1; b1.HSIZE = 3'd2; b1.HADDR = 32'h24;
        @(posedge clk); #1;
        b1.HWDATA = 32'h11111111; b1.HSIZE = 3'd0; b1.HADDR = 32'h25;
        @(negedge clk);
        @(posedge clk); #1;
        b1.HWDATA = 32'h0000EE00; b1.HWRITE = 1'b0; b1.HSIZE = 3'd2; b1.HADDR = 32'h24;
        @(negedge clk);
        chk("byp byte pulse", 32'(b1.HREADYOUT), 32'd1);
        @(posedge clk); #1;
        b1.HTRANS = 2'b00;
        @(negedge clk);
        chk("byp merge pulse", 32'(b1.HREADYOUT), 32'd1);
        chk("byp merge data", b1.HRDATA, 32'h1111EE11);

        // Reset while the read is in its wait state
        @(negedge clk);
        x = '{1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 2'b00, 32'h0, 1};
        xfer(x, rd, resp, lat);
        chk("rst pre-write lat", 32'(lat), 32'd1);
        @(negedge clk);
        b0.HTRANS = 2'b10; b0.HWRITE = 1'b0; b0.HSIZE = 3'd2; b0.HADDR = 32'h30;
        @(posedge clk); #1;
        b0.HTRANS = 2'b00;
        rst_n = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pulses += int'(b0.HREADYOUT);
        end
        chk("rst no pulse", 32'(pulses), 32'd0);
        chk("rst resp", 32'(b0.HRESP), 32'd0);
        chk("rst rdata", b0.HRDATA, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst release ready", 32'(b0.HREADYOUT), 32'd0);
        rd0("rst rd30", 32'h30, 32'h0);
        rd0("rst rd10", 32'h10, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
